// File: rtl/ntt_poly_scheduler.sv
// Job sequencer for the NTT engine: launches one engine run per polynomial, relocates engine
// RAM addresses to the current polynomial and hands the RAM to the host port when idle.
module ntt_poly_scheduler #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_base,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             busy,
  output logic             job_done,
  output logic             job_err,
  output logic [CNT_W-1:0] poly_idx,
  output logic             start_NTT,
  input  logic             done_NTT,
  input  logic [15:0]      eng_A0,
  input  logic [15:0]      eng_A1,
  input  logic [23:0]      eng_D0,
  input  logic [23:0]      eng_D1,
  input  logic             eng_WEB0,
  input  logic             eng_WEB1,
  output logic [15:0]      A0,
  output logic [15:0]      A1,
  output logic [23:0]      D0,
  output logic [23:0]      D1,
  output logic             WEB0,
  output logic             WEB1,
  input  logic [23:0]      Q1,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [15:0]      host_addr,
  input  logic [23:0]      host_wdata,
  output logic             host_gnt,
  output logic [23:0]      host_rdata
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StLaunch, StRun, StNext, StDone} state_e;

  state_e           state_q, state_d;
  logic [15:0]      base_q, base_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] poly_idx_q, poly_idx_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             err_d;
  logic             start_q, done_q, err_q, busy_q;
  logic             eng_sel;
  logic [15:0]      reloc;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^{eng_A0[15:8], eng_A1[15:8]};

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    poly_idx_d = poly_idx_q;
    tmo_d      = tmo_q;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          base_d     = cmd_base;
          count_d    = cmd_count;
          poly_idx_d = '0;
          state_d    = (cmd_count == '0) ? StDone : StLaunch;
        end
      end
      StLaunch: begin
        tmo_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        tmo_d = tmo_q + 1'b1;
        if (done_NTT) begin
          state_d = StNext;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // TIMEOUT cycles spent in RUN without a completion
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StNext: begin
        if (poly_idx_q == count_q - 1'b1) begin
          state_d = StDone;
        end else begin
          poly_idx_d = poly_idx_q + 1'b1;
          state_d    = StLaunch;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      base_q     <= '0;
      count_q    <= '0;
      poly_idx_q <= '0;
      tmo_q      <= '0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      poly_idx_q <= poly_idx_d;
      tmo_q      <= tmo_d;
      // Pulse outputs track the state being entered so they line up with that state
      start_q    <= (state_d == StLaunch);
      done_q     <= (state_d == StDone);
      err_q      <= err_d;
      busy_q     <= (state_d != StIdle);
    end
  end

  assign start_NTT = start_q;
  assign job_done  = done_q;
  assign job_err   = err_q;
  assign busy      = busy_q;
  assign poly_idx  = poly_idx_q;

  assign host_gnt   = rst_n & host_req & (state_q == StIdle);
  assign cmd_ready  = rst_n & ~host_req & (state_q == StIdle);
  assign host_rdata = Q1;

  assign eng_sel = (state_q == StLaunch) || (state_q == StRun) || (state_q == StNext);
  assign reloc   = base_q + 16'({poly_idx_q, 8'h00});

  always_comb begin
    A0   = 16'h0000;
    D0   = 24'h000000;
    WEB0 = 1'b1;
    A1   = host_addr;
    D1   = host_wdata;
    WEB1 = ~(host_gnt & host_we);
    if (eng_sel) begin
      A0   = reloc + {8'h00, eng_A0[7:0]};
      D0   = eng_D0;
      WEB0 = eng_WEB0;
      A1   = reloc + {8'h00, eng_A1[7:0]};
      D1   = eng_D1;
      WEB1 = eng_WEB1;
    end
    if (!rst_n) begin
      WEB0 = 1'b1;
      WEB1 = 1'b1;
    end
  end

endmodule

// File: tb/tb_ntt_poly_scheduler.sv
// Scoreboard bench for ntt_poly_scheduler: expected start/done/read events are queued at
// stimulus time and checked by a monitor when the DUT produces them.
module tb_ntt_poly_scheduler;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned ENG_LAT = 2200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, cmd_valid, cmd_ready, busy, job_done, job_err, start_NTT, done_NTT;
  logic [15:0]      cmd_base, eng_A0, eng_A1, A0, A1, host_addr;
  logic [CNT_W-1:0] cmd_count, poly_idx;
  logic [23:0]      eng_D0, eng_D1, D0, D1, Q1, host_wdata, host_rdata;
  logic             eng_WEB0, eng_WEB1, WEB0, WEB1, host_req, host_we, host_gnt;

  logic             t_cmd_valid, t_cmd_ready, t_busy, t_job_done, t_job_err, t_start;
  logic [CNT_W-1:0] t_poly_idx;
  logic [15:0]      t_A0, t_A1;
  logic [23:0]      t_D0, t_D1, t_host_rdata;
  logic             t_WEB0, t_WEB1, t_host_gnt;
  logic             t_done_ntt = 1'b0;

  ntt_poly_scheduler #(.CNT_W(CNT_W), .TIMEOUT(4095)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_count(cmd_count), .busy(busy), .job_done(job_done),
    .job_err(job_err), .poly_idx(poly_idx), .start_NTT(start_NTT), .done_NTT(done_NTT),
    .eng_A0(eng_A0), .eng_A1(eng_A1), .eng_D0(eng_D0), .eng_D1(eng_D1),
    .eng_WEB0(eng_WEB0), .eng_WEB1(eng_WEB1), .A0(A0), .A1(A1), .D0(D0), .D1(D1),
    .WEB0(WEB0), .WEB1(WEB1), .Q1(Q1), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rdata(host_rdata)
  );

  ntt_poly_scheduler #(.CNT_W(CNT_W), .TIMEOUT(100)) dut_tmo (
    .clk(clk), .rst_n(rst_n), .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready),
    .cmd_base(cmd_base), .cmd_count(cmd_count), .busy(t_busy), .job_done(t_job_done),
    .job_err(t_job_err), .poly_idx(t_poly_idx), .start_NTT(t_start), .done_NTT(t_done_ntt),
    .eng_A0(eng_A0), .eng_A1(eng_A1), .eng_D0(eng_D0), .eng_D1(eng_D1),
    .eng_WEB0(eng_WEB0), .eng_WEB1(eng_WEB1), .A0(t_A0), .A1(t_A1), .D0(t_D0), .D1(t_D1),
    .WEB0(t_WEB0), .WEB1(t_WEB1), .Q1(Q1), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(t_host_gnt),
    .host_rdata(t_host_rdata)
  );

  // Engine model: done_NTT pulses ENG_LAT cycles after start_NTT
  int unsigned eng_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_cnt  <= 0;
      done_NTT <= 1'b0;
    end else begin
      done_NTT <= 1'b0;
      if (start_NTT) begin
        eng_cnt <= ENG_LAT;
      end else if (eng_cnt != 0) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1) done_NTT <= 1'b1;
      end
    end
  end

  logic [23:0] mem [0:65535];
  always @(posedge clk) begin
    if (!WEB1) mem[A1] <= D1;
    Q1 <= mem[A1];
  end

  logic rd_pend = 1'b0;
  always @(posedge clk) rd_pend <= host_gnt & ~host_we;

  typedef struct packed {
    logic [CNT_W-1:0] idx;
    logic [15:0]      a1;
  } start_t;

  start_t      start_q[$];
  logic        done_q[$];
  logic        t_done_q[$];
  logic [23:0] rd_q[$];
  start_t      e_s;
  int          checks = 0, failures = 0, n_start = 0, n_done = 0, t_n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (start_NTT) begin
          n_start++;
          check("start_expected", 32'(start_q.size() != 0), 1);
          if (start_q.size() != 0) begin
            e_s = start_q.pop_front();
            check("start_poly_idx", poly_idx, e_s.idx);
            check("start_A1", A1, e_s.a1);
          end
        end
        if (job_done) begin
          n_done++;
          check("done_expected", 32'(done_q.size() != 0), 1);
          if (done_q.size() != 0) check("job_err", job_err, done_q.pop_front());
        end
        if (rd_pend) begin
          check("rdata_expected", 32'(rd_q.size() != 0), 1);
          if (rd_q.size() != 0) check("host_rdata", host_rdata, rd_q.pop_front());
        end
        if (t_job_done) begin
          t_n_done++;
          check("t_done_expected", 32'(t_done_q.size() != 0), 1);
          if (t_done_q.size() != 0) check("t_job_err", t_job_err, t_done_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n, bad, s0, d0;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_base = '0; cmd_count = '0; t_cmd_valid = 1'b0;
    eng_A0 = 16'h0000; eng_A1 = 16'h0005; eng_D0 = '0; eng_D1 = '0;
    eng_WEB0 = 1'b1; eng_WEB1 = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = '0; host_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_start", start_NTT, 0);
    check("rst_job_done", job_done, 0);
    check("rst_poly_idx", poly_idx, 0);
    check("rst_host_gnt", host_gnt, 0);
    check("rst_WEB0", WEB0, 1);
    check("rst_WEB1", WEB1, 1);
    step();
    rst_n = 1'b1; host_req = 1'b0;
    step();

    // Host wins against a simultaneous command; the host write lands in the same cycle
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0007; host_wdata = 24'h123456;
    cmd_valid = 1'b1; cmd_base = 16'h0400; cmd_count = 3;
    start_q.push_back('{idx: 0, a1: 16'h0405});
    start_q.push_back('{idx: 1, a1: 16'h0505});
    start_q.push_back('{idx: 2, a1: 16'h0605});
    done_q.push_back(1'b0);
    @(negedge clk);
    check("arb_host_gnt", host_gnt, 1);
    check("arb_cmd_ready", cmd_ready, 0);
    check("arb_WEB1", WEB1, 0);
    check("arb_A1", A1, 16'h0007);
    step();
    host_req = 1'b0;
    @(negedge clk);
    check("arb_cmd_ready_next", cmd_ready, 1);
    s0 = n_start; d0 = n_done;
    step();
    cmd_valid = 1'b0;
    host_req = 1'b1;
    n = 0; bad = 0;
    while (busy && n < 8000) begin
      @(negedge clk);
      n++;
      if (busy && (host_gnt || !WEB1 || cmd_ready)) bad++;
    end
    check("job_finished", busy, 0);
    check("host_blocked_in_job", bad, 0);
    check("job_start_count", n_start - s0, 3);
    check("job_done_count", n_done - d0, 1);
    check("host_stall_gnt", host_gnt, 1);
    step();
    host_we = 1'b0;
    rd_q.push_back(24'h123456);
    step();
    host_req = 1'b0;
    step();

    // Zero-length job
    s0 = n_start; d0 = n_done;
    cmd_valid = 1'b1; cmd_count = 0; cmd_base = 16'h1234;
    done_q.push_back(1'b0);
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("cnt0_job_done", job_done, 1);
    step();
    @(negedge clk);
    check("cnt0_idle", busy, 0);
    check("cnt0_no_start", n_start - s0, 0);
    check("cnt0_done_count", n_done - d0, 1);
    step();

    // Address wrap
    cmd_base = 16'hFF80; cmd_count = 2; eng_A0 = 16'h0010;
    start_q.push_back('{idx: 0, a1: 16'hFF85});
    start_q.push_back('{idx: 1, a1: 16'h0085});
    done_q.push_back(1'b0);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (!(start_NTT && poly_idx == 1) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("wrap_poly1_seen", 32'(n < 5000), 1);
    check("wrap_A0", A0, 16'h0090);
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("wrap_finished", busy, 0);
    step();

    // Reset in the middle of RUN
    cmd_base = 16'h0000; cmd_count = 2; eng_A0 = 16'h0000;
    start_q.push_back('{idx: 0, a1: 16'h0005});
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    eng_WEB0 = 1'b0; eng_WEB1 = 1'b0; host_req = 1'b1;
    @(negedge clk);
    check("run_WEB0_passthru", WEB0, 0);
    d0 = n_done;
    step();
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_start", start_NTT, 0);
    check("midrst_job_done", job_done, 0);
    check("midrst_host_gnt", host_gnt, 0);
    check("midrst_WEB0", WEB0, 1);
    check("midrst_WEB1", WEB1, 1);
    step();
    rst_n = 1'b1; eng_WEB0 = 1'b1; eng_WEB1 = 1'b1; host_req = 1'b0;
    @(negedge clk);
    check("midrst_idle_ready", cmd_ready, 1);
    repeat (20) @(negedge clk);
    check("midrst_no_done", n_done - d0, 0);
    check("midrst_busy_after", busy, 0);
    step();

    // Timeout on the TIMEOUT=100 instance; its engine never completes
    cmd_count = 1; cmd_base = 16'h0000;
    t_done_q.push_back(1'b1);
    t_cmd_valid = 1'b1;
    step();
    t_cmd_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!t_start && n < 10);
    check("tmo_start_seen", t_start, 1);
    n = 0;
    while (t_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("tmo_idle_cycles", n, 102);
    check("tmo_done_count", t_n_done, 1);

    repeat (3) step();
    check("scoreboard_empty", start_q.size() + done_q.size() + rd_q.size() + t_done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
